// File: rtl/mul32_seq.sv
// Multi-cycle RV32M multiply: four 16x16 partial products through one external DSP, then sign fix-up.
// Latency: MUL done at cycle 3(1+PP_LAT)+1, MULH/MULHSU/MULHU at 4(1+PP_LAT)+2 after the accepting cycle.
// Backpressure: start is taken only in IDLE; requests while busy (including the done cycle) are dropped.
module mul32_seq #(
  parameter int PP_LAT = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] rs1,
  input  logic [31:0] rs2,
  output logic        busy,
  output logic        done,
  output logic [31:0] result,
  output logic [15:0] dsp_a,
  output logic [15:0] dsp_b,
  input  logic [31:0] dsp_p
);

  localparam int CW = (PP_LAT > 0) ? $clog2(PP_LAT + 1) : 1;
  localparam logic [1:0] OP_MUL    = 2'b00;
  localparam logic [1:0] OP_MULH   = 2'b01;
  localparam logic [1:0] OP_MULHSU = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE, S_P0, S_P1, S_P2, S_P3, S_FIX, S_DONE
  } state_t;

  state_t        state, state_nxt;
  logic [31:0]   a_q, b_q;
  logic [1:0]    op_q;
  logic [63:0]   acc, acc_nxt;
  logic [CW-1:0] wcnt, wcnt_nxt;
  logic          last;
  logic          in_pp;
  logic [31:0]   corr;

  assign last  = (wcnt == CW'(PP_LAT));
  assign in_pp = (state == S_P0) || (state == S_P1) || (state == S_P2) || (state == S_P3);
  assign busy  = (state != S_IDLE);
  assign done  = (state == S_DONE);

  // Signed operands contribute 2^32 * (other operand) too many to the high word.
  always_comb begin
    corr = 32'd0;
    if (a_q[31] && (op_q == OP_MULH || op_q == OP_MULHSU)) corr = corr + b_q;
    if (b_q[31] && (op_q == OP_MULH))                      corr = corr + a_q;
  end

  always_comb begin
    state_nxt = state;
    acc_nxt   = acc;
    dsp_a     = 16'd0;
    dsp_b     = 16'd0;
    wcnt_nxt  = (in_pp && !last) ? wcnt + CW'(1) : CW'(0);
    case (state)
      S_IDLE: begin
        if (start) begin
          state_nxt = S_P0;
          acc_nxt   = 64'd0;
        end
      end
      S_P0: begin
        dsp_a = a_q[15:0];
        dsp_b = b_q[15:0];
        if (last) begin
          acc_nxt   = acc + {32'd0, dsp_p};
          state_nxt = S_P1;
        end
      end
      S_P1: begin
        dsp_a = a_q[15:0];
        dsp_b = b_q[31:16];
        if (last) begin
          acc_nxt   = acc + {16'd0, dsp_p, 16'd0};
          state_nxt = S_P2;
        end
      end
      S_P2: begin
        dsp_a = a_q[31:16];
        dsp_b = b_q[15:0];
        if (last) begin
          acc_nxt   = acc + {16'd0, dsp_p, 16'd0};
          state_nxt = (op_q == OP_MUL) ? S_DONE : S_P3;
        end
      end
      S_P3: begin
        dsp_a = a_q[31:16];
        dsp_b = b_q[31:16];
        if (last) begin
          acc_nxt   = acc + {dsp_p, 32'd0};
          state_nxt = S_FIX;
        end
      end
      S_FIX: begin
        acc_nxt   = {acc[63:32] - corr, acc[31:0]};
        state_nxt = S_DONE;
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      acc    <= 64'd0;
      wcnt   <= CW'(0);
      a_q    <= 32'd0;
      b_q    <= 32'd0;
      op_q   <= OP_MUL;
      result <= 32'd0;
    end else begin
      state <= state_nxt;
      acc   <= acc_nxt;
      wcnt  <= wcnt_nxt;
      if (state == S_IDLE && start) begin
        a_q  <= rs1;
        b_q  <= rs2;
        op_q <= op;
      end
      // Result is captured on entry to DONE so it is valid alongside the done pulse.
      if (state != S_DONE && state_nxt == S_DONE)
        result <= (op_q == OP_MUL) ? acc_nxt[31:0] : acc_nxt[63:32];
    end
  end

endmodule

// File: tb/tb_mul32_seq.sv
// Bench for mul32_seq: one instance with a combinational DSP (PP_LAT=0), one with a 1-cycle DSP (PP_LAT=1).
module tb_mul32_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start_v [2];
  logic [1:0]  op_v    [2];
  logic [31:0] rs1_v   [2];
  logic [31:0] rs2_v   [2];
  logic        busy_v  [2];
  logic        done_v  [2];
  logic [31:0] res_v   [2];
  logic [15:0] dsp_a_v [2];
  logic [15:0] dsp_b_v [2];
  logic [31:0] dsp_p0;
  logic [31:0] dsp_p1_q;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  assign dsp_p0 = 32'(dsp_a_v[0]) * 32'(dsp_b_v[0]);
  always @(posedge clk) dsp_p1_q <= 32'(dsp_a_v[1]) * 32'(dsp_b_v[1]);

  mul32_seq #(.PP_LAT(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .start(start_v[0]), .op(op_v[0]), .rs1(rs1_v[0]), .rs2(rs2_v[0]),
    .busy(busy_v[0]), .done(done_v[0]), .result(res_v[0]),
    .dsp_a(dsp_a_v[0]), .dsp_b(dsp_b_v[0]), .dsp_p(dsp_p0)
  );

  mul32_seq #(.PP_LAT(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start_v[1]), .op(op_v[1]), .rs1(rs1_v[1]), .rs2(rs2_v[1]),
    .busy(busy_v[1]), .done(done_v[1]), .result(res_v[1]),
    .dsp_a(dsp_a_v[1]), .dsp_b(dsp_b_v[1]), .dsp_p(dsp_p1_q)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // RV32M semantics via 64-bit products of sign/zero-extended operands.
  function automatic logic [31:0] ref_mul(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] sa, sb, za, zb, p;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    za = {32'd0, a};
    zb = {32'd0, b};
    case (op)
      2'b00:   begin p = za * zb; return p[31:0];  end
      2'b01:   begin p = sa * sb; return p[63:32]; end
      2'b10:   begin p = sa * zb; return p[63:32]; end
      default: begin p = za * zb; return p[63:32]; end
    endcase
  endfunction

  function automatic int exp_lat(input int lat, input logic [1:0] op);
    return (op == 2'b00) ? 3 * (1 + lat) + 1 : 4 * (1 + lat) + 2;
  endfunction

  // Issues one op; cycle 0 is the cycle start is sampled. With hold, start stays high with
  // fresh random operands through the done cycle, which must all be ignored.
  task automatic do_op(input int sel, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input bit hold, output logic [31:0] res, output int dcyc, output int bcnt);
    int extra;
    @(negedge clk);
    start_v[sel] = 1'b1;
    op_v[sel]    = op;
    rs1_v[sel]   = a;
    rs2_v[sel]   = b;
    @(posedge clk); #1;
    if (!hold) start_v[sel] = 1'b0;
    dcyc = -1;
    bcnt = 0;
    res  = 32'd0;
    for (int c = 1; c <= 40; c++) begin
      if (busy_v[sel]) bcnt++;
      if (done_v[sel]) begin
        dcyc = c;
        res  = res_v[sel];
        break;
      end
      if (hold) begin
        op_v[sel]  = 2'($urandom_range(0, 3));
        rs1_v[sel] = $urandom;
        rs2_v[sel] = $urandom;
      end
      @(posedge clk); #1;
    end
    if (dcyc < 0) chk("done_timeout", 64'd1, 64'd0);
    @(posedge clk); #1;
    start_v[sel] = 1'b0;
    chk("idle_after_done", 64'(busy_v[sel]), 64'd0);
    extra = 0;
    for (int c = 0; c < 3; c++) begin
      if (done_v[sel] || busy_v[sel]) extra++;
      @(posedge clk); #1;
    end
    chk("no_extra_done", 64'(extra), 64'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] res;
    logic [1:0]  op;
    logic [31:0] a, b;
    int dcyc, bcnt;

    for (int i = 0; i < 2; i++) begin
      start_v[i] = 1'b0;
      op_v[i]    = 2'b00;
      rs1_v[i]   = 32'd0;
      rs2_v[i]   = 32'd0;
    end
    #12;
    for (int i = 0; i < 2; i++) begin
      chk("rst_busy",   64'(busy_v[i]),  64'd0);
      chk("rst_done",   64'(done_v[i]),  64'd0);
      chk("rst_result", 64'(res_v[i]),   64'd0);
      chk("rst_dsp_a",  64'(dsp_a_v[i]), 64'd0);
      chk("rst_dsp_b",  64'(dsp_b_v[i]), 64'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;

    do_op(0, 2'b00, 32'd7, 32'hFFFFFFFD, 1'b0, res, dcyc, bcnt);
    chk("mul_small_res", 64'(res), 64'hFFFFFFEB);
    chk("mul_small_cyc", 64'(dcyc), 64'd4);
    chk("mul_small_busy", 64'(bcnt), 64'd4);

    do_op(0, 2'b01, 32'h80000000, 32'h80000000, 1'b0, res, dcyc, bcnt);
    chk("mulh_minmin_res", 64'(res), 64'h40000000);
    chk("mulh_minmin_cyc", 64'(dcyc), 64'd6);
    do_op(0, 2'b01, 32'hFFFFFFFF, 32'h00000002, 1'b0, res, dcyc, bcnt);
    chk("mulh_neg_res", 64'(res), 64'hFFFFFFFF);
    chk("mulh_neg_cyc", 64'(dcyc), 64'd6);

    do_op(0, 2'b10, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, res, dcyc, bcnt);
    chk("mulhsu_res", 64'(res), 64'hFFFFFFFF);
    do_op(0, 2'b11, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, res, dcyc, bcnt);
    chk("mulhu_res", 64'(res), 64'hFFFFFFFE);

    do_op(0, 2'b00, 32'h00012345, 32'h00000100, 1'b1, res, dcyc, bcnt);
    chk("hold_res", 64'(res), 64'h01234500);
    chk("hold_cyc", 64'(dcyc), 64'd4);
    chk("hold_result_kept", 64'(res_v[0]), 64'h01234500);

    // Asynchronous reset while in P2 of a MULH.
    @(negedge clk);
    start_v[0] = 1'b1;
    op_v[0]    = 2'b01;
    rs1_v[0]   = 32'h89ABCDEF;
    rs2_v[0]   = 32'hFEDCBA98;
    @(posedge clk); #1;
    start_v[0] = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("p2_busy", 64'(busy_v[0]), 64'd1);
    chk("p2_dsp_a", 64'(dsp_a_v[0]), 64'h89AB);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy",   64'(busy_v[0]),  64'd0);
    chk("mid_rst_done",   64'(done_v[0]),  64'd0);
    chk("mid_rst_result", 64'(res_v[0]),   64'd0);
    chk("mid_rst_dsp_a",  64'(dsp_a_v[0]), 64'd0);
    chk("mid_rst_dsp_b",  64'(dsp_b_v[0]), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    do_op(0, 2'b01, 32'h89ABCDEF, 32'hFEDCBA98, 1'b0, res, dcyc, bcnt);
    chk("post_rst_res", 64'(res), 64'(ref_mul(2'b01, 32'h89ABCDEF, 32'hFEDCBA98)));
    chk("post_rst_cyc", 64'(dcyc), 64'd6);

    do_op(1, 2'b11, 32'h12345678, 32'h9ABCDEF0, 1'b0, res, dcyc, bcnt);
    chk("lat1_mulhu_res", 64'(res), 64'h0B00EA4E);
    chk("lat1_mulhu_cyc", 64'(dcyc), 64'd10);
    do_op(1, 2'b00, 32'hDEADBEEF, 32'h12345679, 1'b0, res, dcyc, bcnt);
    chk("lat1_mul_res", 64'(res), 64'(ref_mul(2'b00, 32'hDEADBEEF, 32'h12345679)));
    chk("lat1_mul_cyc", 64'(dcyc), 64'd7);

    for (int i = 0; i < 60; i++) begin
      int sel;
      sel = (i < 40) ? 0 : 1;
      op  = 2'($urandom_range(0, 3));
      a   = $urandom;
      b   = $urandom;
      if (i % 8 == 3) a = 32'h80000000;
      if (i % 8 == 5) b = 32'hFFFFFFFF;
      do_op(sel, op, a, b, 1'b0, res, dcyc, bcnt);
      chk("rand_res", 64'(res), 64'(ref_mul(op, a, b)));
      chk("rand_cyc", 64'(dcyc), 64'(exp_lat(sel, op)));
    end

    $display("[TB] %0d tests run, %0d failed", n_chk, n_fail);
    $finish;
  end

endmodule
